imem_loader: RTL and testbench

Byte-stream program loader that writes the instruction memory the core fetches from. It sits beside `instruction_memory`, drives that memory's write port, and holds the core's active-low reset until a complete image has been written. Input is a valid/ready byte stream from a host link, such as a UART receiver or debug bridge. The stream carries a 4-byte little-endian word-count header followed by little-endian instruction words.

---
 rtl/pkg_config.sv | 16 +
 rtl/loader_word_packer.sv | 37 +++
 rtl/imem_loader.sv | 181 ++++++++++++++++++
 tb/tb_imem_loader.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pkg_config.sv
// Shared loader configuration: state encoding and sizing defaults.
package pkg_config;

    localparam int unsigned LOADER_MAX_WORDS = 1024;
    localparam int unsigned LOADER_HDR_BYTES = 4;

    typedef enum logic [2:0] {
        LD_IDLE  = 3'd0,
        LD_HDR   = 3'd1,
        LD_DATA  = 3'd2,
        LD_CHECK = 3'd3,
        LD_DONE  = 3'd4,
        LD_ERR   = 3'd5
    } loader_state_e;

endpackage

// File: rtl/loader_word_packer.sv
// Assembles strobed bytes LSB-first into 32-bit words; shared by header and data phases.
// The completed word and its pulse are combinational so the caller can register them on the 4th byte's edge.
module loader_word_packer
    import pkg_config::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        clr_i,
    input  logic        strobe_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_c_o,
    output logic        word_done_c_o
);

    localparam int unsigned LANE_W = $clog2(LOADER_HDR_BYTES);

    logic [LANE_W-1:0] lane_q;
    logic [23:0]       shift_q;

    // Newest byte lands on top, so after four bytes the first one sits in [7:0].
    assign word_c_o      = {byte_i, shift_q};
    assign word_done_c_o = strobe_i && (lane_q == LANE_W'(LOADER_HDR_BYTES - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lane_q  <= '0;
            shift_q <= '0;
        end else if (clr_i) begin
            lane_q  <= '0;
            shift_q <= '0;
        end else if (strobe_i) begin
            lane_q  <= lane_q + LANE_W'(1);
            shift_q <= word_c_o[31:8];
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader; holds the core in reset until an image is written.
// Optional trailing checksum byte enabled by defining LOADER_CHECKSUM_EN.
module imem_loader
    import pkg_config::*;
#(
    parameter int unsigned MAX_WORDS  = LOADER_MAX_WORDS,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_i,
    output logic                  byte_ready_o,
    input  logic                  start_i,
    output logic                  imem_we_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    output logic [31:0]           imem_data_o,
    output logic                  core_rst_n_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);

    loader_state_e         state_q;
    logic [31:0]           cnt_q;
    logic [31:0]           idx_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           data_q;
    logic                  ready_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
    logic                  core_rst_n_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            sum_q;
`endif

    logic        xfer_c;
    logic        pack_stb_c;
    logic        pack_clr_c;
    logic [31:0] word_c;
    logic        word_done_c;
    logic        last_word_c;

    assign xfer_c      = byte_valid_i && ready_q;
    assign pack_stb_c  = xfer_c && ((state_q == LD_HDR) || (state_q == LD_DATA));
    assign pack_clr_c  = start_i && ((state_q == LD_DONE) || (state_q == LD_ERR));
    assign last_word_c = (idx_q == (cnt_q - 32'd1));

    loader_word_packer u_packer (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .clr_i         (pack_clr_c),
        .strobe_i      (pack_stb_c),
        .byte_i        (byte_i),
        .word_c_o      (word_c),
        .word_done_c_o (word_done_c)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= LD_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            core_rst_n_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            we_q <= 1'b0;
            case (state_q)
                LD_IDLE: begin
                    state_q <= LD_HDR;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b1;
                end
                LD_HDR: begin
                    if (word_done_c) begin
                        cnt_q <= word_c;
                        idx_q <= '0;
                        if (word_c == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state_q <= LD_CHECK;
`else
                            state_q <= LD_DONE;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
`endif
                        end else if (word_c > 32'(MAX_WORDS)) begin
                            state_q <= LD_ERR;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= LD_DATA;
                        end
                    end
                end
                LD_DATA: begin
`ifdef LOADER_CHECKSUM_EN
                    if (xfer_c) begin
                        sum_q <= sum_q + byte_i;
                    end
`endif
                    if (word_done_c) begin
                        we_q   <= 1'b1;
                        addr_q <= ADDR_WIDTH'(idx_q << 2);
                        data_q <= word_c;
                        idx_q  <= idx_q + 32'd1;
                        if (last_word_c) begin
`ifdef LOADER_CHECKSUM_EN
                            state_q <= LD_CHECK;
`else
                            state_q <= LD_DONE;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                LD_CHECK: begin
                    if (xfer_c) begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                        if (8'(sum_q + byte_i) == 8'd0) begin
                            state_q <= LD_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= LD_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
`endif
                LD_DONE, LD_ERR: begin
                    // Core leaves reset one cycle after DONE so the final write has landed.
                    if (state_q == LD_DONE) begin
                        core_rst_n_q <= 1'b1;
                    end
                    if (start_i) begin
                        state_q      <= LD_HDR;
                        cnt_q        <= '0;
                        idx_q        <= '0;
                        ready_q      <= 1'b1;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        err_q        <= 1'b0;
                        core_rst_n_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        sum_q        <= '0;
`endif
                    end
                end
                default: begin
                    state_q <= LD_IDLE;
                end
            endcase
        end
    end

    assign byte_ready_o = ready_q;
    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_data_o  = data_q;
    assign core_rst_n_o = core_rst_n_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign error_o      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed table-driven bench for imem_loader in its default (no checksum) build.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_d = 8'h00;
    logic        start = 1'b0;
    logic        ready;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        core_rst_n;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    // Flag groups: {ready, busy, done, error, core_rst_n}
    localparam logic [4:0] RUN  = 5'b11000;
    localparam logic [4:0] DN0  = 5'b00100;
    localparam logic [4:0] DN1  = 5'b00101;
    localparam logic [4:0] ERRF = 5'b00010;

    typedef struct packed {
        logic        valid;
        logic [7:0]  b;
        logic        start;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [4:0]  flg;
    } vec_t;

    vec_t vecs[$];

    imem_loader #(.MAX_WORDS(1024), .ADDR_WIDTH(32)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .byte_valid_i (byte_valid),
        .byte_i       (byte_d),
        .byte_ready_o (ready),
        .start_i      (start),
        .imem_we_o    (we),
        .imem_addr_o  (addr),
        .imem_data_o  (data),
        .core_rst_n_o (core_rst_n),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (err)
    );

    always #5 clk = ~clk;

    function automatic logic [69:0] outs();
        return {we, addr, data, ready, busy, done, err, core_rst_n};
    endfunction

    task automatic check(input string name, input logic [69:0] exp);
        n_checks++;
        if (outs() !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, outs(), exp);
        end
    endtask

    task automatic add(input logic v, input logic [7:0] b, input logic s, input logic w,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] f);
        vec_t t;
        t = '{valid: v, b: b, start: s, we: w, addr: a, data: d, flg: f};
        vecs.push_back(t);
    endtask

    // Drive one cycle from a negedge, check just after the posedge, return at the next negedge.
    task automatic send(input logic v, input logic [7:0] b, input logic s, input string name,
                        input logic [69:0] exp);
        byte_valid = v;
        byte_d     = b;
        start      = s;
        @(posedge clk);
        #1;
        check(name, exp);
        @(negedge clk);
    endtask

    initial begin
        // Scenario 1: N=2 image after reset release
        add(0, 8'h00, 0, 0, 32'h0, 32'h0, RUN);
        add(1, 8'h02, 0, 0, 32'h0, 32'h0, RUN);
        add(1, 8'h00, 0, 0, 32'h0, 32'h0, RUN);
        add(1, 8'h00, 0, 0, 32'h0, 32'h0, RUN);
        add(1, 8'h00, 0, 0, 32'h0, 32'h0, RUN);
        add(1, 8'h13, 0, 0, 32'h0, 32'h0, RUN);
        add(1, 8'h00, 0, 0, 32'h0, 32'h0, RUN);
        add(1, 8'h00, 0, 0, 32'h0, 32'h0, RUN);
        add(1, 8'h00, 0, 1, 32'h0, 32'h00000013, RUN);
        add(1, 8'h93, 0, 0, 32'h0, 32'h00000013, RUN);
        add(1, 8'h00, 0, 0, 32'h0, 32'h00000013, RUN);
        add(1, 8'h10, 0, 0, 32'h0, 32'h00000013, RUN);
        add(1, 8'h00, 0, 1, 32'h4, 32'h00100093, DN0);
        add(0, 8'h00, 0, 0, 32'h4, 32'h00100093, DN1);
        add(1, 8'h55, 0, 0, 32'h4, 32'h00100093, DN1);
        // Scenario 2: reload with N=0
        add(0, 8'h00, 1, 0, 32'h4, 32'h00100093, RUN);
        add(1, 8'h00, 0, 0, 32'h4, 32'h00100093, RUN);
        add(1, 8'h00, 0, 0, 32'h4, 32'h00100093, RUN);
        add(1, 8'h00, 0, 0, 32'h4, 32'h00100093, RUN);
        add(1, 8'h00, 0, 0, 32'h4, 32'h00100093, DN0);
        add(0, 8'h00, 0, 0, 32'h4, 32'h00100093, DN1);
        // Scenario 3: N=0x401 rejected, then restart
        add(0, 8'h00, 1, 0, 32'h4, 32'h00100093, RUN);
        add(1, 8'h01, 0, 0, 32'h4, 32'h00100093, RUN);
        add(1, 8'h04, 0, 0, 32'h4, 32'h00100093, RUN);
        add(1, 8'h00, 0, 0, 32'h4, 32'h00100093, RUN);
        add(1, 8'h00, 0, 0, 32'h4, 32'h00100093, ERRF);
        add(1, 8'hAA, 0, 0, 32'h4, 32'h00100093, ERRF);
        add(0, 8'h00, 1, 0, 32'h4, 32'h00100093, RUN);
        // Scenario 4: scenario 1 with valid low every other cycle; start ignored mid-DATA
        add(0, 8'h00, 0, 0, 32'h4, 32'h00100093, RUN);
        add(1, 8'h02, 0, 0, 32'h4, 32'h00100093, RUN);
        add(0, 8'h00, 0, 0, 32'h4, 32'h00100093, RUN);
        add(1, 8'h00, 0, 0, 32'h4, 32'h00100093, RUN);
        add(0, 8'h00, 0, 0, 32'h4, 32'h00100093, RUN);
        add(1, 8'h00, 0, 0, 32'h4, 32'h00100093, RUN);
        add(0, 8'h00, 0, 0, 32'h4, 32'h00100093, RUN);
        add(1, 8'h00, 0, 0, 32'h4, 32'h00100093, RUN);
        add(0, 8'h00, 1, 0, 32'h4, 32'h00100093, RUN);
        add(1, 8'h13, 0, 0, 32'h4, 32'h00100093, RUN);
        add(0, 8'h00, 0, 0, 32'h4, 32'h00100093, RUN);
        add(1, 8'h00, 0, 0, 32'h4, 32'h00100093, RUN);
        add(0, 8'h00, 0, 0, 32'h4, 32'h00100093, RUN);
        add(1, 8'h00, 0, 0, 32'h4, 32'h00100093, RUN);
        add(0, 8'h00, 0, 0, 32'h4, 32'h00100093, RUN);
        add(1, 8'h00, 0, 1, 32'h0, 32'h00000013, RUN);
        add(0, 8'h00, 0, 0, 32'h0, 32'h00000013, RUN);
        add(1, 8'h93, 0, 0, 32'h0, 32'h00000013, RUN);
        add(0, 8'h00, 1, 0, 32'h0, 32'h00000013, RUN);
        add(1, 8'h00, 0, 0, 32'h0, 32'h00000013, RUN);
        add(0, 8'h00, 0, 0, 32'h0, 32'h00000013, RUN);
        add(1, 8'h10, 0, 0, 32'h0, 32'h00000013, RUN);
        add(0, 8'h00, 0, 0, 32'h0, 32'h00000013, RUN);
        add(1, 8'h00, 0, 1, 32'h4, 32'h00100093, DN0);
        add(0, 8'h00, 0, 0, 32'h4, 32'h00100093, DN1);
        // Scenario 5: reload N=1 with 0xDEADBEEF
        add(0, 8'h00, 1, 0, 32'h4, 32'h00100093, RUN);
        add(1, 8'h01, 0, 0, 32'h4, 32'h00100093, RUN);
        add(1, 8'h00, 0, 0, 32'h4, 32'h00100093, RUN);
        add(1, 8'h00, 0, 0, 32'h4, 32'h00100093, RUN);
        add(1, 8'h00, 0, 0, 32'h4, 32'h00100093, RUN);
        add(1, 8'hEF, 0, 0, 32'h4, 32'h00100093, RUN);
        add(1, 8'hBE, 0, 0, 32'h4, 32'h00100093, RUN);
        add(1, 8'hAD, 0, 0, 32'h4, 32'h00100093, RUN);
        add(1, 8'hDE, 0, 1, 32'h0, 32'hDEADBEEF, DN0);
        add(0, 8'h00, 0, 0, 32'h0, 32'hDEADBEEF, DN1);

        repeat (3) @(negedge clk);
        check("reset_state", 70'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].valid, vecs[i].b, vecs[i].start, $sformatf("vec%0d", i),
                 {vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].flg});
        end

        // Start another load, then pull reset asynchronously in the middle of DATA
        send(0, 8'h00, 1, "mid_start", {1'b0, 32'h0, 32'hDEADBEEF, RUN});
        send(1, 8'h02, 0, "mid_h0", {1'b0, 32'h0, 32'hDEADBEEF, RUN});
        send(1, 8'h00, 0, "mid_h1", {1'b0, 32'h0, 32'hDEADBEEF, RUN});
        send(1, 8'h00, 0, "mid_h2", {1'b0, 32'h0, 32'hDEADBEEF, RUN});
        send(1, 8'h00, 0, "mid_h3", {1'b0, 32'h0, 32'hDEADBEEF, RUN});
        send(1, 8'h11, 0, "mid_d0", {1'b0, 32'h0, 32'hDEADBEEF, RUN});
        send(1, 8'h22, 0, "mid_d1", {1'b0, 32'h0, 32'hDEADBEEF, RUN});
        byte_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 70'd0);
        @(posedge clk);
        #1;
        check("reset_hold", 70'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 8'h00, 0, "reset_recover", {1'b0, 32'h0, 32'h0, RUN});
        send(1, 8'h00, 0, "recover_ready", {1'b0, 32'h0, 32'h0, RUN});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
